// File: rtl/aes_word_frontend_if.sv
// Word-stream bundle for the AES front-end: one 32-bit valid/ready input stream
// and one 32-bit valid/ready result stream.
interface aes_word_frontend_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_word_frontend.sv
// Streaming front-end for aes_core: packs four input words into a block, loads the
// core, waits on busy with a watchdog, then drains the 128-bit result as four words.
module aes_word_frontend #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_word_frontend_if.slave  strm,
    input  logic [255:0]        key_i,
    input  logic [1:0]          size_i,
    input  logic                dec_i,
    output logic                err_timeout,
    output logic                core_load_o,
    output logic [255:0]        core_key_o,
    output logic [127:0]        core_data_o,
    output logic [1:0]          core_size_o,
    output logic                core_dec_o,
    input  logic [127:0]        core_data_i,
    input  logic                core_busy_i
);

    typedef enum logic [2:0] {
        ST_FILL,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      wcnt_reg;
    logic [1:0]      ocnt_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic [95:0]     shift_reg;
    logic [255:0]    key_reg;
    logic [1:0]      size_reg;
    logic            dec_reg;
    logic [127:0]    core_data_reg;
    logic [255:0]    core_key_reg;
    logic [1:0]      core_size_reg;
    logic            core_dec_reg;
    logic [127:0]    result_reg;
    logic            err_reg;

    logic            in_ready_c;
    logic            out_valid_c;
    logic            load_c;
    logic [31:0]     out_data_c;
    logic            in_fire;
    logic            out_fire;
    logic            timeout_hit;
    logic [31:0]     res_word [4];

    assign in_fire     = strm.in_valid & in_ready_c;
    assign out_fire    = strm.out_ready & out_valid_c;
    assign timeout_hit = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

    // Word 0 is the most significant word of the block.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_res_word
            assign res_word[gi] = result_reg[127 - 32*gi -: 32];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FILL:  if (in_fire && wcnt_reg == 2'd3) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_START;
            ST_START: begin
                if (core_busy_i)      state_next = ST_WAIT;
                else if (timeout_hit) state_next = ST_FILL;
            end
            ST_WAIT: begin
                if (!core_busy_i)     state_next = ST_DRAIN;
                else if (timeout_hit) state_next = ST_FILL;
            end
            ST_DRAIN: if (out_fire && ocnt_reg == 2'd3) state_next = ST_FILL;
            default:  state_next = ST_FILL;
        endcase
    end

    always_comb begin
        in_ready_c  = (state_reg == ST_FILL);
        out_valid_c = (state_reg == ST_DRAIN);
        load_c      = (state_reg == ST_LOAD);
        out_data_c  = 32'd0;
        if (state_reg == ST_DRAIN) out_data_c = res_word[ocnt_reg];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_reg      <= '0;
            ocnt_reg      <= '0;
            to_cnt_reg    <= '0;
            shift_reg     <= '0;
            key_reg       <= '0;
            size_reg      <= '0;
            dec_reg       <= 1'b0;
            core_data_reg <= '0;
            core_key_reg  <= '0;
            core_size_reg <= '0;
            core_dec_reg  <= 1'b0;
            result_reg    <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (in_fire) begin
                shift_reg <= {shift_reg[63:0], strm.in_data};
                wcnt_reg  <= wcnt_reg + 2'd1;
                if (wcnt_reg == 2'd0) begin
                    key_reg  <= key_i;
                    size_reg <= size_i;
                    dec_reg  <= dec_i;
                    err_reg  <= 1'b0;
                end
                // Core-facing copies stay stable until the next block is complete.
                if (wcnt_reg == 2'd3) begin
                    core_data_reg <= {shift_reg, strm.in_data};
                    core_key_reg  <= key_reg;
                    core_size_reg <= size_reg;
                    core_dec_reg  <= dec_reg;
                end
            end

            if (state_reg == ST_LOAD) begin
                to_cnt_reg <= '0;
            end else if (state_reg == ST_START || state_reg == ST_WAIT) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end

            if ((state_reg == ST_START && !core_busy_i && timeout_hit) ||
                (state_reg == ST_WAIT && core_busy_i && timeout_hit)) begin
                err_reg <= 1'b1;
            end

            if (state_reg == ST_WAIT && !core_busy_i) begin
                result_reg <= core_data_i;
                ocnt_reg   <= 2'd0;
            end else if (out_fire) begin
                ocnt_reg <= ocnt_reg + 2'd1;
            end
        end
    end

    assign strm.in_ready  = in_ready_c;
    assign strm.out_valid = out_valid_c;
    assign strm.out_data  = out_data_c;
    assign core_load_o    = load_c;
    assign core_data_o    = core_data_reg;
    assign core_key_o     = core_key_reg;
    assign core_size_o    = core_size_reg;
    assign core_dec_o     = core_dec_reg;
    assign err_timeout    = err_reg;

endmodule

// File: tb/tb_aes_word_frontend.sv
// Directed bench for aes_word_frontend with a behavioural aes_core stub that knows
// the FIPS-197 AES-128 vector in both directions.
module tb_aes_word_frontend;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K128 =
        256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
    localparam int LAT_ENC = 10;
    localparam int LAT_DEC = 14;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key_i;
    logic [1:0]   size_i;
    logic         dec_i;
    logic         err_timeout;
    logic         core_load_o;
    logic [255:0] core_key_o;
    logic [127:0] core_data_o;
    logic [1:0]   core_size_o;
    logic         core_dec_o;
    logic [127:0] stub_out;
    logic         stub_busy;

    aes_word_frontend_if bus ();

    aes_word_frontend #(.TIMEOUT_CYCLES(64), .TO_W(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .strm        (bus.slave),
        .key_i       (key_i),
        .size_i      (size_i),
        .dec_i       (dec_i),
        .err_timeout (err_timeout),
        .core_load_o (core_load_o),
        .core_key_o  (core_key_o),
        .core_data_o (core_data_o),
        .core_size_o (core_size_o),
        .core_dec_o  (core_dec_o),
        .core_data_i (stub_out),
        .core_busy_i (stub_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int load_cnt = 0;
    int ov_cnt   = 0;
    int acc_cyc  = 0;
    int drain_cyc = 0;
    logic stub_dead = 1'b0;
    int   stub_cnt  = 0;
    logic [127:0] stub_pend;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Core stub: only the known FIPS-197 block is modelled faithfully.
    function automatic logic [127:0] core_ref(input logic [255:0] k, input logic [1:0] sz,
                                              input logic d, input logic [127:0] blk);
        if (k == K128 && sz == 2'd0 && !d && blk == PT) return CT;
        if (k == K128 && sz == 2'd0 && d && blk == CT)  return PT;
        return blk ^ {4{32'hdeadbeef}};
    endfunction

    initial begin
        stub_busy = 1'b0;
        stub_out  = '0;
        stub_pend = '0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_load_o) begin
            stub_busy <= !stub_dead;
            stub_cnt  <= core_dec_o ? LAT_DEC : LAT_ENC;
            stub_pend <= core_ref(core_key_o, core_size_o, core_dec_o, core_data_o);
        end else if (stub_busy) begin
            if (stub_cnt == 1) begin
                stub_busy <= 1'b0;
                stub_out  <= stub_pend;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (core_load_o) load_cnt++;
        if (bus.out_valid) ov_cnt++;
    end

    task automatic send_word(input logic [31:0] w, input bit gap);
        int  guard;
        bit  acc;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        do begin
            acc = bus.in_ready;
            @(posedge clk); #1;
            guard++;
        end while (!acc && guard < 500);
        if (!acc) check("send_accept", 0, 1);
        acc_cyc = cyc;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_block(input logic [127:0] blk, input bit gap, input logic d);
        key_i  = K128;
        size_i = 2'd0;
        dec_i  = d;
        for (int i = 0; i < 4; i++) send_word(blk[127 - 32*i -: 32], gap);
        bus.in_valid = 1'b0;
    endtask

    task automatic recv_block(input string tag, input logic [127:0] exp,
                              input int stall_word, input int stall_len);
        int guard;
        logic [31:0] ew;
        for (int i = 0; i < 4; i++) begin
            ew = exp[127 - 32*i -: 32];
            guard = 0;
            while (!bus.out_valid && guard < 300) begin
                @(posedge clk); #1;
                guard++;
            end
            if (!bus.out_valid) begin
                check({tag, "_valid_wait"}, 0, 1);
                return;
            end
            if (i == stall_word) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge clk); #1;
                    check({tag, "_stall_data"}, bus.out_data, ew);
                    check({tag, "_stall_valid"}, bus.out_valid, 1);
                end
            end
            check({tag, "_in_ready_drain"}, bus.in_ready, 0);
            check($sformatf("%s_word%0d", tag, i), bus.out_data, ew);
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            drain_cyc = cyc;
        end
        check({tag, "_valid_after"}, bus.out_valid, 0);
    endtask

    task automatic measure_latency(input string tag, input int core_lat, output int edges);
        edges = 0;
        while (!bus.out_valid && edges < 300) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, edges + 1, core_lat + 3);
    endtask

    initial begin
        int enc_edges, dec_edges, base_load, base_ov, b2w0_cyc, d1_cyc, guard;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        key_i = '0; size_i = '0; dec_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_err", err_timeout, 0);
        check("rst_load", core_load_o, 0);
        check("rst_core_data", core_data_o, 0);
        check("rst_core_key", core_key_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // AES-128 encrypt
        base_load = load_cnt;
        send_block(PT, 1'b0, 1'b0);
        check("enc_load_next", core_load_o, 1);
        check("enc_core_data", core_data_o, PT);
        check("enc_core_key", core_key_o, K128);
        check("enc_in_ready_load", bus.in_ready, 0);
        measure_latency("enc", LAT_ENC, enc_edges);
        recv_block("enc", CT, -1, 0);
        check("enc_load_once", load_cnt - base_load, 1);

        // AES-128 decrypt of the ciphertext
        send_block(CT, 1'b0, 1'b1);
        check("dec_core_dec", core_dec_o, 1);
        measure_latency("dec", LAT_DEC, dec_edges);
        check("dec_longer", dec_edges > enc_edges, 1);
        recv_block("dec", PT, -1, 0);

        // input gaps and output backpressure
        send_block(PT, 1'b1, 1'b0);
        recv_block("bp", CT, 1, 5);

        // timeout with a core that never raises busy
        stub_dead = 1'b1;
        base_ov = ov_cnt;
        send_block(PT, 1'b0, 1'b0);
        check("to_load", core_load_o, 1);
        repeat (63) begin @(posedge clk); #1; end
        check("to_err_early", err_timeout, 0);
        repeat (3) begin @(posedge clk); #1; end
        check("to_err_set", err_timeout, 1);
        check("to_in_ready", bus.in_ready, 1);
        check("to_no_out", ov_cnt - base_ov, 0);
        stub_dead = 1'b0;
        key_i = K128; size_i = 2'd0; dec_i = 1'b0;
        send_word(PT[127:96], 1'b0);
        check("to_err_cleared", err_timeout, 0);
        send_word(PT[95:64], 1'b0);
        send_word(PT[63:32], 1'b0);
        send_word(PT[31:0], 1'b0);
        bus.in_valid = 1'b0;
        recv_block("to_next", CT, -1, 0);

        // reset while the core is busy
        send_block(PT, 1'b0, 1'b0);
        guard = 0;
        while (!stub_busy && guard < 50) begin @(posedge clk); #1; guard++; end
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rstw_out_valid", bus.out_valid, 0);
        check("rstw_in_ready", bus.in_ready, 1);
        check("rstw_core_data", core_data_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_block(PT, 1'b0, 1'b0);
        recv_block("rstw", CT, -1, 0);

        // back-to-back blocks with in_valid held high
        b2w0_cyc = 0;
        d1_cyc = 0;
        key_i = K128; size_i = 2'd0; dec_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_word(PT[127 - 32*(i % 4) -: 32], 1'b0);
                    if (i == 4) b2w0_cyc = acc_cyc;
                end
                bus.in_valid = 1'b0;
            end
            begin
                recv_block("b2b1", CT, -1, 0);
                d1_cyc = drain_cyc;
                recv_block("b2b2", CT, -1, 0);
            end
        join
        check("b2b_order", b2w0_cyc > d1_cyc, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/aes_word_frontend.md
Name: aes_word_frontend

Overview:
- Streaming front-end wrapped around the AES core (aes_core). It sits directly upstream of the core's load interface and directly downstream of its data_o/busy_o outputs.
- Input side: assembles four 32-bit input words into one 128-bit block. It then issues a single-cycle load to the core with the key, size and direction settings.
- Wait: holds while the core is busy, with a watchdog timeout.
- Output side: captures the 128-bit result and drains it as four 32-bit words.
- Both streams use valid/ready handshakes. Only one block is in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles from the load pulse to the core's busy falling before an error is declared.
- TO_W, 7: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  32  input word; word 0 maps to block[127:96], word 3 to block[31:0]
- key_i  in  256  key, passed unmodified to the core; sampled on acceptance of word 0
- size_i  in  2  key size (0=128, 1=192, 2=256); sampled with key_i
- dec_i  in  1  1 = decrypt; sampled with key_i
- out_valid  out  1  result word valid
- out_ready  in  1  result word consumed when out_valid & out_ready
- out_data  out  32  result word, same word order as input
- err_timeout  out  1  sticky: core did not complete in time; cleared by acceptance of the next word 0
- core_load_o  out  1  to core load_i
- core_key_o  out  256  to core key_i
- core_data_o  out  128  to core data_i
- core_size_o  out  2  to core size_i
- core_dec_o  out  1  to core dec_i
- core_data_i  in  128  from core data_o
- core_busy_i  in  1  from core busy_o

Behaviour:
- Reset (async, rst_n=0) forces:
  - state FILL, word count 0, timeout counter 0;
  - in_ready=1, out_valid=0, out_data=0, err_timeout=0;
  - core_load_o=0, core_data_o=0, core_key_o=0, core_size_o=0, core_dec_o=0.
- Reset mid-operation abandons the block and discards partial input and output.
  - The core has no reset. A load issued after reset restarts the core regardless of its state.
- States: FILL -> LOAD -> START -> WAIT -> DRAIN -> FILL.
- FILL
  - in_ready=1.
  - Each accepted word is shifted into the block register and increments the 2-bit word count.
  - On word 0: sample key_i/size_i/dec_i into registers and clear err_timeout.
  - On word 3 accepted: the count wraps to 0, state goes to LOAD, and in_ready drops the next cycle.
- LOAD
  - core_load_o=1 for exactly one cycle.
  - core_data_o/key/size/dec hold the assembled values from this cycle until the next FILL completes.
  - Timeout counter cleared. Next state START.
- START
  - Waits for core_busy_i=1; the core raises busy the cycle after load.
  - If core_busy_i=1, go to WAIT.
  - Timeout counter increments each cycle in START and WAIT.
- WAIT
  - On core_busy_i=0: capture core_data_i into the result register and go to DRAIN with word index 0.
- Timeout (START or WAIT)
  - If the counter reaches TIMEOUT_CYCLES before busy falls: set err_timeout, discard the result, go to FILL, emit no output words.
- DRAIN
  - out_valid=1 and out_data = the result word at the current index.
  - Handshake rules: valid held, data stable, no drop under backpressure.
  - Index advances on each handshake.
  - The handshake on word 3 returns to FILL with out_valid=0 the next cycle.
  - in_ready=0 throughout DRAIN; there is no overlap of the next input block with draining.
- Latency
  - Last input word accepted -> load asserted the next cycle.
  - Busy fall observed -> first out_valid the next cycle.
  - End-to-end latency = core latency + 3 cycles.
- in_valid is ignored outside FILL. out_ready is ignored outside DRAIN.

Test Plan:
- AES-128 encrypt:
  - Stimulus: key_i[255:128]=000102030405060708090a0b0c0d0e0f, rest 0, size 0, dec 0, words 00112233, 44556677, 8899aabb, ccddeeff.
  - Required: out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; core_load_o high exactly one cycle.
- Decrypt of the above ciphertext with the same key, dec=1 -> out words 00112233 … ccddeeff, and longer WAIT than encrypt.
- Input gaps and output backpressure:
  - Stimulus: in_valid toggled every other cycle; out_ready low for 5 cycles on word 1.
  - Required: out_data stable at 6a7b0430 while stalled; correct final sequence; in_ready=0 during DRAIN.
- Timeout: core stub holds busy low -> err_timeout=1 after 64 cycles, no out_valid, in_ready=1; the next word 0 clears err_timeout.
- Reset mid-WAIT:
  - Stimulus: rst_n low for 1 cycle.
  - Required: out_valid=0 and in_ready=1 immediately; a new block then completes correctly with the correct result.
- Back-to-back blocks: two blocks streamed with in_valid held high -> word 0 of block 2 is accepted only after word 3 of block 1 is drained.
